// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator sequencing controller:
//   - state_e   : 2-bit FSM state encoding (also shown on the debug LEDs)
//   - OP_ADD/SUB: encoding of the op_sel switch
//   - CALC_W    : default operand/result width
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    SHOW  = 2'd3
  } state_e;

endpackage : calc_pkg

// File: rtl/calc_seq_ctrl_btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
// Brings an asynchronous (already debounced) button level into the clk domain
// with a 2-FF synchronizer and emits a single-clk pulse on its rising edge.
// Holding the button produces no further pulses.
//   clk   in  system clock
//   reset in  synchronous, active-high; clears all flops (drops a pending edge)
//   d     in  raw asynchronous button level
//   pulse out one-clk pulse, high in the cycle after the synchronized rise
// -----------------------------------------------------------------------------
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so all three flops
  // sample their pre-edge values and the chain shifts by exactly one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Decoded from flops only, so the consumer acts on the third edge after
  // the input rises.
  assign pulse = sync2_q & ~prev_q;

endmodule : btn_edge_sync

// File: rtl/calc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// calc_seq_ctrl
// Sequencing controller for the 8-bit add/subtract calculator. Operand A and
// operand B are taken from the switches on successive enter presses, the
// operation is executed for one clk, and the result is shown until the next
// enter or until TIMEOUT_TICKS display ticks elapse.
//   clk          in  system clock
//   reset        in  synchronous, active-high
//   enter        in  asynchronous debounced enter button level
//   sw           in  operand switches (two's complement)
//   op_sel       in  0 = add, 1 = subtract; captured with operand B
//   tick         in  one-clk pulse from the display divider (~5 Hz)
//   disp_val     out value for the 7-segment output unit
//   disp_blank   out blink control while an operand is being entered
//   result_valid out high while the result is shown
//   ovf          out signed overflow of the last operation
//   state_o      out current FSM state for debug LEDs
// -----------------------------------------------------------------------------
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int W             = CALC_W,
  parameter int TIMEOUT_TICKS = 25,
  parameter int TCW           = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enter,
  input  logic [W-1:0] sw,
  input  logic         op_sel,
  input  logic         tick,
  output logic [W-1:0] disp_val,
  output logic         disp_blank,
  output logic         result_valid,
  output logic         ovf,
  output logic [1:0]   state_o
);

  localparam logic [TCW-1:0] CNT_LAST = TCW'(TIMEOUT_TICKS - 1);
  localparam logic [TCW-1:0] CNT_MAX  = {TCW{1'b1}};

  state_e         state_q;
  logic [W-1:0]   a_q, b_q, result_q, disp_val_q;
  logic           op_q, ovf_q, disp_blank_q, result_valid_q;
  logic [TCW-1:0] cnt_q;

  logic           enter_pulse;
  logic [W-1:0]   result_d;
  logic           ovf_d;

  btn_edge_sync u_enter_sync (
    .clk   (clk),
    .reset (reset),
    .d     (enter),
    .pulse (enter_pulse)
  );

  // Arithmetic and signed overflow, consumed only in EXEC.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result_d = a_q + b_q;
    ovf_d    = (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
    if (op_q == OP_SUB) begin
      result_d = a_q - b_q;
      ovf_d    = (a_q[W-1] != b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= GET_A;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      op_q           <= OP_ADD;
      ovf_q          <= 1'b0;
      disp_val_q     <= '0;
      disp_blank_q   <= 1'b0;
      result_valid_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      unique case (state_q)
        GET_A, GET_B: begin
          disp_val_q     <= sw;
          result_valid_q <= 1'b0;
          if (enter_pulse) begin
            // A coincident tick is dropped so the next operand starts unblanked.
            disp_blank_q <= 1'b0;
            if (state_q == GET_A) begin
              a_q     <= sw;
              state_q <= GET_B;
            end else begin
              b_q     <= sw;
              op_q    <= op_sel;
              state_q <= EXEC;
            end
          end else if (tick) begin
            disp_blank_q <= ~disp_blank_q;
          end
        end

        EXEC: begin
          result_q       <= result_d;
          ovf_q          <= ovf_d;
          disp_val_q     <= result_d;
          disp_blank_q   <= 1'b0;
          result_valid_q <= 1'b1;
          cnt_q          <= '0;
          state_q        <= SHOW;
        end

        SHOW: begin
          disp_val_q   <= result_q;
          disp_blank_q <= 1'b0;
          // Enter and timeout share one exit, so their coincidence is benign.
          if (enter_pulse || (tick && cnt_q == CNT_LAST)) begin
            state_q        <= GET_A;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            result_valid_q <= 1'b0;
          end else if (tick && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: state_q <= GET_A;
      endcase
    end
  end

  assign disp_val     = disp_val_q;
  assign disp_blank   = disp_blank_q;
  assign result_valid = result_valid_q;
  assign ovf          = ovf_q;
  assign state_o      = state_q;

endmodule : calc_seq_ctrl

// File: tb/tb_calc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_calc_seq_ctrl
// Directed bench for calc_seq_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
// -----------------------------------------------------------------------------
module tb_calc_seq_ctrl;

  localparam logic [1:0] S_GET_A = 2'd0;
  localparam logic [1:0] S_GET_B = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_SHOW  = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       op_sel = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] disp_val;
  logic       disp_blank;
  logic       result_valid;
  logic       ovf;
  logic [1:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  calc_seq_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enter        (enter),
    .sw           (sw),
    .op_sel       (op_sel),
    .tick         (tick),
    .disp_val     (disp_val),
    .disp_blank   (disp_blank),
    .result_valid (result_valid),
    .ovf          (ovf),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic press_enter();
    @(negedge clk) enter = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) enter = 1'b0;
  endtask

  task automatic load_a(input logic [7:0] v);
    @(negedge clk) sw = v;
    press_enter();
  endtask

  // Returns at the falling edge where the DUT sits in EXEC.
  task automatic load_b_to_exec(input logic [7:0] v, input logic op);
    @(negedge clk) begin sw = v; op_sel = op; enter = 1'b1; end
    repeat (3) @(posedge clk);
    @(negedge clk) enter = 1'b0;
  endtask

  task automatic run_to_show(input logic [7:0] a, input logic [7:0] b, input logic op);
    load_a(a);
    load_b_to_exec(b, op);
    @(negedge clk);
  endtask

  task automatic give_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", state_o, S_GET_A); end
    vectors++; if (disp_val !== 8'h00) begin miscompares++; $display("FAIL reset_disp_val: got %0h expected 00", disp_val); end
    vectors++; if (disp_blank !== 1'b0) begin miscompares++; $display("FAIL reset_blank: got %b expected 0", disp_blank); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    load_a(8'd5);
    vectors++; if (state_o !== S_GET_B) begin miscompares++; $display("FAIL add_get_b: got %0d expected %0d", state_o, S_GET_B); end
    load_b_to_exec(8'd3, 1'b0);
    vectors++; if (state_o !== S_EXEC) begin miscompares++; $display("FAIL add_exec: got %0d expected %0d", state_o, S_EXEC); end
    @(negedge clk);
    vectors++; if (state_o !== S_SHOW) begin miscompares++; $display("FAIL add_show: got %0d expected %0d", state_o, S_SHOW); end
    vectors++; if (disp_val !== 8'h08) begin miscompares++; $display("FAIL add_val: got %0h expected 08", disp_val); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL add_ovf: got %b expected 0", ovf); end
    vectors++; if (result_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b expected 1", result_valid); end
    press_enter();
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL add_home: got %0d expected %0d", state_o, S_GET_A); end
  endtask

  task automatic test_subtract();
    run_to_show(8'd5, 8'd3, 1'b1);
    vectors++; if (disp_val !== 8'h02) begin miscompares++; $display("FAIL sub_5m3: got %0h expected 02", disp_val); end
    // Switches moving while the result is shown must not disturb it.
    @(negedge clk) sw = 8'h55;
    repeat (3) @(negedge clk);
    vectors++; if (disp_val !== 8'h02) begin miscompares++; $display("FAIL sub_sw_hold: got %0h expected 02", disp_val); end
    press_enter();
    run_to_show(8'd3, 8'd5, 1'b1);
    vectors++; if (disp_val !== 8'hFE) begin miscompares++; $display("FAIL sub_3m5: got %0h expected fe", disp_val); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL sub_3m5_ovf: got %b expected 0", ovf); end
    press_enter();
  endtask

  task automatic test_overflow();
    run_to_show(8'd100, 8'd100, 1'b0);
    vectors++; if (disp_val !== 8'hC8) begin miscompares++; $display("FAIL ovf_add_val: got %0h expected c8", disp_val); end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_add_flag: got %b expected 1", ovf); end
    press_enter();
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_add_clear: got %b expected 0", ovf); end
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL ovf_add_home: got %0d expected %0d", state_o, S_GET_A); end
    run_to_show(8'h80, 8'h01, 1'b1);
    vectors++; if (disp_val !== 8'h7F) begin miscompares++; $display("FAIL ovf_sub_val: got %0h expected 7f", disp_val); end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sub_flag: got %b expected 1", ovf); end
    press_enter();
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_sub_clear: got %b expected 0", ovf); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_sub_valid: got %b expected 0", result_valid); end
  endtask

  task automatic test_timeout();
    run_to_show(8'd2, 8'd2, 1'b0);
    repeat (24) give_tick();
    vectors++; if (state_o !== S_SHOW) begin miscompares++; $display("FAIL tmo_24: got %0d expected %0d", state_o, S_SHOW); end
    give_tick();
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL tmo_25: got %0d expected %0d", state_o, S_GET_A); end
    // Enter pulse lands on the same edge as the 25th tick.
    run_to_show(8'd4, 8'd1, 1'b0);
    repeat (24) give_tick();
    @(negedge clk) enter = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL tmo_enter_coinc: got %0d expected %0d", state_o, S_GET_A); end
    repeat (4) @(negedge clk);
    enter = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL tmo_no_double: got %0d expected %0d", state_o, S_GET_A); end
  endtask

  task automatic test_blink();
    @(negedge clk) sw = 8'h3C;
    @(negedge clk);
    vectors++; if (disp_val !== 8'h3C) begin miscompares++; $display("FAIL blink_follow_sw: got %0h expected 3c", disp_val); end
    vectors++; if (disp_blank !== 1'b0) begin miscompares++; $display("FAIL blink_start: got %b expected 0", disp_blank); end
    give_tick();
    vectors++; if (disp_blank !== 1'b1) begin miscompares++; $display("FAIL blink_tick1: got %b expected 1", disp_blank); end
    give_tick();
    vectors++; if (disp_blank !== 1'b0) begin miscompares++; $display("FAIL blink_tick2: got %b expected 0", disp_blank); end
    give_tick();
    // Tick coincident with the enter pulse: toggle discarded, blank forced low.
    @(negedge clk) enter = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    vectors++; if (state_o !== S_GET_B) begin miscompares++; $display("FAIL blink_enter_state: got %0d expected %0d", state_o, S_GET_B); end
    vectors++; if (disp_blank !== 1'b0) begin miscompares++; $display("FAIL blink_enter_forced: got %b expected 0", disp_blank); end
    enter = 1'b0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    load_a(8'd7);
    give_tick();
    vectors++; if (state_o !== S_GET_B) begin miscompares++; $display("FAIL midop_in_b: got %0d expected %0d", state_o, S_GET_B); end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL midop_state: got %0d expected %0d", state_o, S_GET_A); end
    vectors++; if (disp_blank !== 1'b0) begin miscompares++; $display("FAIL midop_blank: got %b expected 0", disp_blank); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL midop_ovf: got %b expected 0", ovf); end
    run_to_show(8'd1, 8'd1, 1'b0);
    vectors++; if (disp_val !== 8'h02) begin miscompares++; $display("FAIL midop_1p1: got %0h expected 02", disp_val); end
    press_enter();
  endtask

  task automatic test_edge();
    @(negedge clk) enter = 1'b1;
    repeat (50) @(negedge clk);
    vectors++; if (state_o !== S_GET_B) begin miscompares++; $display("FAIL edge_hold: got %0d expected %0d", state_o, S_GET_B); end
    enter = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (state_o !== S_GET_B) begin miscompares++; $display("FAIL edge_hold_release: got %0d expected %0d", state_o, S_GET_B); end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    // One-clk-wide press covering a single sampling edge.
    enter = 1'b1;
    @(posedge clk);
    @(negedge clk) enter = 1'b0;
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL edge_short_e1: got %0d expected %0d", state_o, S_GET_A); end
    @(negedge clk);
    vectors++; if (state_o !== S_GET_A) begin miscompares++; $display("FAIL edge_short_e2: got %0d expected %0d", state_o, S_GET_A); end
    @(negedge clk);
    vectors++; if (state_o !== S_GET_B) begin miscompares++; $display("FAIL edge_short_e3: got %0d expected %0d", state_o, S_GET_B); end
    repeat (4) @(negedge clk);
    vectors++; if (state_o !== S_GET_B) begin miscompares++; $display("FAIL edge_short_once: got %0d expected %0d", state_o, S_GET_B); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_overflow();
    test_timeout();
    test_blink();
    test_reset_midop();
    test_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_calc_seq_ctrl

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencing controller for the 8-bit two-function (add/subtract) calculator datapath.
- Takes operands from the slide switches on successive presses of an enter button and latches the operation select.
- Performs the signed 8-bit operation and drives the value to be shown on the output_unit 7-segment chain.
- Sits between board I/O (switches, button, divided display tick) and output_unit. It replaces the free-running counter as the display source in the calculator top level.

Parameters:
- W, 8, operand/result width; two's complement.
- TIMEOUT_TICKS, 25, number of tick pulses in SHOW with no enter before auto-return to GET_A (25 ticks at 5 Hz = 5 s).
- TCW, 5, width of the timeout counter; must satisfy 2^TCW > TIMEOUT_TICKS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- enter  in  1  raw, asynchronous, already-debounced button level.
- sw  in  W  operand switches, sampled as signed.
- op_sel  in  1  operation select: 0 = add, 1 = subtract; sampled at the second enter.
- tick  in  1  single-clk pulse from the clock divider chain, nominally 5 Hz.
- disp_val  out  W  signed value for output_unit.the_input.
- disp_blank  out  1  display blanking for blink.
- result_valid  out  1  high while in SHOW.
- ovf  out  1  signed overflow of the last operation.
- state_o  out  2  current state, for debug LEDs.

Behaviour:
- States (2-bit encoding): GET_A = 0, GET_B = 1, EXEC = 2, SHOW = 3.
- Reset values:
  - state = GET_A; operand A, operand B, result register and op register = 0.
  - disp_val = 0, disp_blank = 0, result_valid = 0, ovf = 0.
  - Timeout counter = 0; synchronizer and edge flops = 0.
- Enter path:
  - enter goes through a 2-FF synchronizer, then a rising-edge detector.
  - enter_pulse is high for exactly 1 clk.
  - The state register changes on the clk edge where enter_pulse = 1, i.e. 3 clk edges after enter rises ahead of a sampling edge.
  - Holding enter high produces no further pulses.
- GET_A:
  - disp_val follows sw combinationally through a registered stage (1 clk latency).
  - disp_blank toggles on every tick.
  - On enter_pulse: A <= sw, go to GET_B, disp_blank <= 0.
- GET_B:
  - Same display and blink behaviour as GET_A.
  - On enter_pulse: B <= sw, op <= op_sel, go to EXEC.
- EXEC: exactly 1 clk.
  - result <= A + B or A - B, truncated to W bits.
  - ovf <= signed overflow:
    - add: A and B have the same sign and the result sign differs.
    - sub: A and B have different signs and the result sign differs from A.
  - Go to SHOW. enter_pulse is ignored in this state.
- SHOW:
  - disp_val = result, disp_blank = 0, result_valid = 1.
  - The timeout counter increments on each tick.
  - On enter_pulse: go to GET_A, clear counter, clear ovf.
  - When the counter reaches TIMEOUT_TICKS - 1 and tick = 1: go to GET_A, clear counter, clear ovf.
  - If enter_pulse and the timeout occur in the same clk, the enter path is taken. Both lead to the same end state.
  - The counter saturates rather than wraps.
- Simultaneous events:
  - A tick in the same cycle as the enter_pulse that leaves GET_A/GET_B: the blink toggle is discarded and disp_blank is forced to 0.
- Reset mid-operation: any state returns to GET_A on the next edge. Latched A, B and result are cleared, and a pending edge in the synchronizer is discarded.
- sw changing during EXEC/SHOW has no effect on the result.

Decomposition:
- Shared package calc_pkg holds:
  - state encodings GET_A/GET_B/EXEC/SHOW;
  - OP_ADD = 0, OP_SUB = 1;
  - default W = 8.
- One sub-module, btn_edge_sync: 2-FF synchronizer plus rising-edge detector, with ports clk, reset, d, pulse. It is reusable by other button inputs.
- The arithmetic and overflow logic stays inline; it is small.

Test Plan:
- Add: sw = 5, enter; sw = 3, op_sel = 0, enter → state passes through EXEC, then SHOW with disp_val = 8, ovf = 0, result_valid = 1.
- Subtract: A = 5, B = 3, op_sel = 1 → disp_val = 2. Also A = 3, B = 5, op_sel = 1 → disp_val = 0xFE (−2), ovf = 0.
- Overflow:
  - 100 + 100 → disp_val = 0xC8 (−56), ovf = 1.
  - −128 − 1 → disp_val = 0x7F (127), ovf = 1.
  - Next enter clears ovf and returns to GET_A.
- Timeout: in SHOW, apply 24 ticks → still SHOW; the 25th tick → GET_A on that edge. An enter on the same clk as the 25th tick → GET_A, with no double-advance into GET_B.
- Edge handling: hold enter high for 50 clks in GET_A → exactly one advance to GET_B. Pulse enter 1 clk wide between edges → still one advance, 3 clks after the rise.
- Reset mid-op: assert reset for 1 clk while in GET_B with A = 7 latched → GET_A, disp_blank = 0, ovf = 0. A subsequent full sequence with 1 + 1 gives disp_val = 2.
